bytewrite_tdp_ram_cfg: RTL and testbench
========================================

Name: bytewrite_tdp_ram_cfg

Overview:
Single-clock true dual-port RAM with per-byte write enables. It is the parametrised successor of the team's byte-write TDP RAM.
- Write behaviour is selectable per port: write-first, read-first or no-change.
- Output pipeline depth and address width are parametrised.
- Each port has a read-valid output.
- Same-address collisions have a defined resolution and are counted.
- Used as the generic BRAM macro in the memory validation suite.

Parameters:
NB_COL, 4, number of byte columns
COL_WIDTH, 9, bits per column
RAM_DEPTH, 1024, number of words
ADDR_WIDTH, $clog2(RAM_DEPTH) = 10, address width
WRITE_MODE_A, 0, port A write mode: 0 = write-first, 1 = read-first, 2 = no-change
WRITE_MODE_B, 0, port B write mode, same encoding
OUT_REG, 1, 1 = output register present (2-cycle read latency); 0 = 1-cycle read latency
COLL_PRIO, 0, winner of a same-byte write-write collision: 0 = port A, 1 = port B

Ports:
clk  in  1  single clock, both ports
rst  in  1  reset, synchronous, active-high; affects outputs/counters only, never memory contents
ena  in  1  port A enable
wea  in  NB_COL  port A byte write enables
addra  in  ADDR_WIDTH  port A address
dina  in  NB_COL*COL_WIDTH  port A write data
regcea  in  1  port A output register enable (ignored when OUT_REG=0)
douta  out  NB_COL*COL_WIDTH  port A read data
douta_vld  out  1  port A read data valid, one-cycle pulse per accepted read
enb, web, addrb, dinb, regceb, doutb, doutb_vld: port B mirror of the port A signals
coll  out  1  registered pulse: same-address access with at least one write
coll_cnt  out  16  saturating collision count

Behaviour:
- Reset values: douta, doutb, stage-1 data registers = 0; all vld outputs = 0; coll = 0; coll_cnt = 0. Memory contents are unaffected.
- Write (cycle N):
  - ena=1: each byte i with wea[i]=1 is written to mem[addra] at the edge.
  - Writes in a rst cycle still happen.
- Stage-1 data register (ram_data_a), loaded at edge N when ena=1:
  - write-first: written bytes take dina, unwritten bytes take old memory contents.
  - read-first: the full old word.
  - no-change with |wea=1: ram_data_a holds its value.
- Stage-1 valid: vld_s1 = ena & ~rst, except in no-change mode, where vld_s1 = ena & ~|wea & ~rst.
- OUT_REG=0: douta = ram_data_a, douta_vld = vld_s1; latency 1.
- OUT_REG=1:
  - At edge N+1, if regcea=1: douta <= ram_data_a and douta_vld <= vld_s1.
  - If regcea=0: douta holds and douta_vld <= 0.
  - Latency 2.
- rst=1 in any cycle: all vld outputs and output/stage-1 registers clear at that edge. Reads in flight are dropped, with no late vld.
- Collision condition: ena & enb & (addra==addrb) & (|wea | |web).
  - Write-write on the same byte: the COLL_PRIO port's data is stored.
  - Non-overlapping bytes from both ports are all written.
  - A reading port sees the pre-edge memory contents for bytes written by the other port. Its own written bytes still follow its own write mode.
- coll: asserted at edge N+1 for a collision in cycle N.
- coll_cnt: increments at the same edge and saturates at 16'hFFFF.
- rst clears coll/coll_cnt and takes priority over an increment in the same cycle.
- Address ≥ RAM_DEPTH (non-power-of-2 depth): write ignored, read returns 0, vld still asserted.
- Port B is fully symmetric with port A.

Decomposition:
- Package bram_cfg_pkg holds:
  - write-mode constants WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2
  - collision-priority constants
  - the clog2 function
- Sub-module bram_port_pipe (instantiated twice) holds one port's stage-1 mux, valid pipeline and optional output register.
- The memory array and collision logic stay in the top module.

Test Plan:
1. Port A writes 0x1_2345_6789 to addr 5 with wea=4'hF, then reads addr 5 with regcea=1 and OUT_REG=1 → douta=0x123456789 and douta_vld=1 exactly 2 cycles after the read.
2. Write-first vs read-first: addr 7 holds 0; A writes wea=4'b0011 with dina=all 1s.
   - Write-first → douta = 0x0_0003_FFFF.
   - Read-first (WRITE_MODE_A=1) → douta=0.
3. No-change: prior read of addr 3 returns 0xAAA; A then writes addr 3 → douta stays 0xAAA and douta_vld stays 0 for that access.
4. Same-cycle writes to addr 9: A wea=4'hF, dina=0x111111111; B web=4'h3, dinb=0x222222222; COLL_PRIO=0.
   - Readback of addr 9 = 0x111111111.
   - coll pulses 1 cycle later; coll_cnt=1.
5. Reset mid-read: A reads addr 5 in cycle N, rst=1 in cycle N+1 → douta=0 and no douta_vld pulse.
   - Subsequent readback of addr 5 is unchanged.
6. 65540 consecutive collision cycles → coll_cnt = 16'hFFFF. Asserting rst → coll_cnt = 0 on the next edge.

Source files
------------

// File: rtl/bram_cfg_pkg.sv
// Shared constants and helpers for the configurable byte-write TDP RAM.
// Write-mode encodings, collision-priority encodings and a clog2 helper.
package bram_cfg_pkg;

   localparam int WM_WRITE_FIRST = 0;
   localparam int WM_READ_FIRST  = 1;
   localparam int WM_NO_CHANGE   = 2;

   localparam int PRIO_A = 0;
   localparam int PRIO_B = 1;

   // Ceiling log2, never below 1 so a one-word RAM still has an address bit.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/bram_port_pipe.sv
// One RAM port's read path: stage-1 write-mode mux, valid and optional output register.
// Ports: clk, rst, en, we, in_range, din, rd_word (pre-edge word), regce -> dout, dout_vld.
module bram_port_pipe
   import bram_cfg_pkg::*;
#(
   parameter int NB_COL     = 4,
   parameter int COL_WIDTH  = 9,
   parameter int WRITE_MODE = 0,
   parameter int OUT_REG    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NB_COL-1:0]           we,
   input  logic                        in_range,
   input  logic [NB_COL*COL_WIDTH-1:0] din,
   input  logic [NB_COL*COL_WIDTH-1:0] rd_word,
   input  logic                        regce,
   output logic [NB_COL*COL_WIDTH-1:0] dout,
   output logic                        dout_vld
);

   localparam int W = NB_COL * COL_WIDTH;

   logic [W-1:0] merged;
   logic [W-1:0] data_s1_d;
   logic [W-1:0] data_s1_q;
   logic         vld_s1_d;
   logic         vld_s1_q;

   // Write-first view: own written bytes replace the old word.
   // Out-of-range accesses write nothing and read as zero.
   always_comb begin
      merged = rd_word;
      for (int i = 0; i < NB_COL; i++) begin
         if (we[i] && in_range) begin
            merged[i*COL_WIDTH +: COL_WIDTH] = din[i*COL_WIDTH +: COL_WIDTH];
         end
      end
   end

   always_comb begin
      data_s1_d = data_s1_q;
      vld_s1_d  = en;
      if (WRITE_MODE == WM_NO_CHANGE) begin
         vld_s1_d = en & ~(|we);
      end
      if (en) begin
         if (WRITE_MODE == WM_WRITE_FIRST) begin
            data_s1_d = merged;
         end else if (WRITE_MODE == WM_READ_FIRST) begin
            data_s1_d = rd_word;
         end else if (~(|we)) begin
            data_s1_d = rd_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_s1_q <= '0;
         vld_s1_q  <= 1'b0;
      end else begin
         data_s1_q <= data_s1_d;
         vld_s1_q  <= vld_s1_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [W-1:0] dout_d;
         logic [W-1:0] dout_q;
         logic         dout_vld_d;
         logic         dout_vld_q;

         // regce low freezes the data but never repeats a valid pulse.
         always_comb begin
            dout_d     = dout_q;
            dout_vld_d = 1'b0;
            if (regce) begin
               dout_d     = data_s1_q;
               dout_vld_d = vld_s1_q;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               dout_q     <= '0;
               dout_vld_q <= 1'b0;
            end else begin
               dout_q     <= dout_d;
               dout_vld_q <= dout_vld_d;
            end
         end

         assign dout     = dout_q;
         assign dout_vld = dout_vld_q;
      end else begin : g_noreg
         logic unused_regce;
         assign unused_regce = regce;
         assign dout         = data_s1_q;
         assign dout_vld     = vld_s1_q;
      end
   endgenerate

endmodule

// File: rtl/bytewrite_tdp_ram_cfg.sv
// Single-clock true dual-port RAM with byte enables, per-port write modes and collision count.
// Ports: clk, rst, port A/B (en, we, addr, din, regce -> dout, dout_vld), coll, coll_cnt.
module bytewrite_tdp_ram_cfg
   import bram_cfg_pkg::*;
#(
   parameter int NB_COL       = 4,
   parameter int COL_WIDTH    = 9,
   parameter int RAM_DEPTH    = 1024,
   parameter int ADDR_WIDTH   = clog2(RAM_DEPTH),
   parameter int WRITE_MODE_A = 0,
   parameter int WRITE_MODE_B = 0,
   parameter int OUT_REG      = 1,
   parameter int COLL_PRIO    = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   input  logic [NB_COL-1:0]           wea,
   input  logic [ADDR_WIDTH-1:0]       addra,
   input  logic [NB_COL*COL_WIDTH-1:0] dina,
   input  logic                        regcea,
   output logic [NB_COL*COL_WIDTH-1:0] douta,
   output logic                        douta_vld,
   input  logic                        enb,
   input  logic [NB_COL-1:0]           web,
   input  logic [ADDR_WIDTH-1:0]       addrb,
   input  logic [NB_COL*COL_WIDTH-1:0] dinb,
   input  logic                        regceb,
   output logic [NB_COL*COL_WIDTH-1:0] doutb,
   output logic                        doutb_vld,
   output logic                        coll,
   output logic [15:0]                 coll_cnt
);

   localparam int W = NB_COL * COL_WIDTH;

   logic [W-1:0] mem [RAM_DEPTH];

   logic              in_range_a;
   logic              in_range_b;
   logic [W-1:0]      rd_a;
   logic [W-1:0]      rd_b;
   logic [NB_COL-1:0] wr_a;
   logic [NB_COL-1:0] wr_b;

   logic              coll_d;
   logic              coll_q;
   logic [15:0]       coll_cnt_d;
   logic [15:0]       coll_cnt_q;

   assign in_range_a = int'(addra) < RAM_DEPTH;
   assign in_range_b = int'(addrb) < RAM_DEPTH;

   // Both ports see the pre-edge word; the other port's write lands later.
   assign rd_a = in_range_a ? mem[addra] : '0;
   assign rd_b = in_range_b ? mem[addrb] : '0;

   // On a same-address overlap the losing port drops the contested bytes.
   always_comb begin
      wr_a = (ena && in_range_a) ? wea : '0;
      wr_b = (enb && in_range_b) ? web : '0;
      if (addra == addrb) begin
         if (COLL_PRIO == PRIO_A) begin
            wr_b = wr_b & ~wr_a;
         end else begin
            wr_a = wr_a & ~wr_b;
         end
      end
   end

   // Array has no reset: rst only touches the read pipelines and counters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB_COL; i++) begin
         if (wr_a[i]) begin
            mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
         end
         if (wr_b[i]) begin
            mem[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
         end
      end
   end

   bram_port_pipe #(
      .NB_COL     (NB_COL),
      .COL_WIDTH  (COL_WIDTH),
      .WRITE_MODE (WRITE_MODE_A),
      .OUT_REG    (OUT_REG)
   ) u_pipe_a (
      .clk      (clk),
      .rst      (rst),
      .en       (ena),
      .we       (wea),
      .in_range (in_range_a),
      .din      (dina),
      .rd_word  (rd_a),
      .regce    (regcea),
      .dout     (douta),
      .dout_vld (douta_vld)
   );

   bram_port_pipe #(
      .NB_COL     (NB_COL),
      .COL_WIDTH  (COL_WIDTH),
      .WRITE_MODE (WRITE_MODE_B),
      .OUT_REG    (OUT_REG)
   ) u_pipe_b (
      .clk      (clk),
      .rst      (rst),
      .en       (enb),
      .we       (web),
      .in_range (in_range_b),
      .din      (dinb),
      .rd_word  (rd_b),
      .regce    (regceb),
      .dout     (doutb),
      .dout_vld (doutb_vld)
   );

   always_comb begin
      coll_d     = ena & enb & (addra == addrb) & ((|wea) | (|web));
      coll_cnt_d = coll_cnt_q;
      if (coll_d && coll_cnt_q != 16'hFFFF) begin
         coll_cnt_d = coll_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coll_q     <= 1'b0;
         coll_cnt_q <= '0;
      end else begin
         coll_q     <= coll_d;
         coll_cnt_q <= coll_cnt_d;
      end
   end

   assign coll     = coll_q;
   assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_bytewrite_tdp_ram_cfg.sv
// Self-checking bench for bytewrite_tdp_ram_cfg: two configurations driven in lockstep.
// Directed scenarios plus random traffic, compared against a behavioural memory model.
module tb_bytewrite_tdp_ram_cfg;

   localparam int W = 36;

   // dut0: write-first both ports, output register, A wins.
   // dut1: A read-first, B no-change, no output register, B wins.
   localparam int WMA  [2] = '{0, 1};
   localparam int WMB  [2] = '{0, 2};
   localparam int OREG [2] = '{1, 0};
   localparam int PRIO [2] = '{0, 1};

   logic         clk = 1'b0;
   logic         rst;
   logic         ena, enb;
   logic [3:0]   wea, web;
   logic [9:0]   addra, addrb;
   logic [W-1:0] dina, dinb;
   logic         regcea, regceb;

   logic [W-1:0] douta_o [2];
   logic [W-1:0] doutb_o [2];
   logic         douta_vld_o [2];
   logic         doutb_vld_o [2];
   logic         coll_o [2];
   logic [15:0]  coll_cnt_o [2];

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] m_mem [2][1024];
   logic [W-1:0] m_s1  [2][2];
   logic         m_v1  [2][2];
   logic [W-1:0] m_out [2][2];
   logic         m_ov  [2][2];
   logic         m_coll [2];
   logic [15:0]  m_cnt  [2];

   always #5 clk = ~clk;

   bytewrite_tdp_ram_cfg u_dut0 (
      .clk(clk), .rst(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
      .douta(douta_o[0]), .douta_vld(douta_vld_o[0]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .regceb(regceb),
      .doutb(doutb_o[0]), .doutb_vld(doutb_vld_o[0]),
      .coll(coll_o[0]), .coll_cnt(coll_cnt_o[0])
   );

   bytewrite_tdp_ram_cfg #(
      .WRITE_MODE_A(1), .WRITE_MODE_B(2), .OUT_REG(0), .COLL_PRIO(1)
   ) u_dut1 (
      .clk(clk), .rst(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
      .douta(douta_o[1]), .douta_vld(douta_vld_o[1]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .regceb(regceb),
      .doutb(doutb_o[1]), .doutb_vld(doutb_vld_o[1]),
      .coll(coll_o[1]), .coll_cnt(coll_cnt_o[1])
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] merge(input logic [W-1:0] old,
                                          input logic [W-1:0] din,
                                          input logic [3:0] we);
      logic [W-1:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (we[i]) r[i*9 +: 9] = din[i*9 +: 9];
      return r;
   endfunction

   // One clock: snapshot inputs, advance the model at the edge, then compare.
   task automatic cyc();
      logic         s_rst;
      logic         en [2];
      logic [3:0]   we [2];
      logic [9:0]   ad [2];
      logic [W-1:0] di [2];
      logic         rc [2];
      logic [W-1:0] old, ns1;
      logic         nv1, c;
      int           mode, first;
      s_rst = rst;
      en[0] = ena; we[0] = wea; ad[0] = addra; di[0] = dina; rc[0] = regcea;
      en[1] = enb; we[1] = web; ad[1] = addrb; di[1] = dinb; rc[1] = regceb;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            old  = m_mem[k][ad[p]];
            mode = (p == 0) ? WMA[k] : WMB[k];
            ns1  = m_s1[k][p];
            if (en[p]) begin
               if (mode == 0) ns1 = merge(old, di[p], we[p]);
               else if (mode == 1) ns1 = old;
               else if (we[p] == 4'h0) ns1 = old;
            end
            nv1 = en[p] && !(mode == 2 && we[p] != 4'h0);
            if (s_rst) begin
               ns1 = '0;
               nv1 = 1'b0;
            end
            if (OREG[k] != 0) begin
               if (s_rst) begin
                  m_out[k][p] = '0;
                  m_ov[k][p]  = 1'b0;
               end else if (rc[p]) begin
                  m_out[k][p] = m_s1[k][p];
                  m_ov[k][p]  = m_v1[k][p];
               end else begin
                  m_ov[k][p]  = 1'b0;
               end
            end else begin
               m_out[k][p] = ns1;
               m_ov[k][p]  = nv1;
            end
            m_s1[k][p] = ns1;
            m_v1[k][p] = nv1;
         end
         // Loser writes first so the winner overwrites shared bytes.
         first = (PRIO[k] == 0) ? 1 : 0;
         if (en[first])
            m_mem[k][ad[first]] = merge(m_mem[k][ad[first]], di[first], we[first]);
         if (en[1-first])
            m_mem[k][ad[1-first]] = merge(m_mem[k][ad[1-first]], di[1-first], we[1-first]);
         c = en[0] && en[1] && ad[0] == ad[1] && (we[0] != 0 || we[1] != 0);
         m_coll[k] = s_rst ? 1'b0 : c;
         if (s_rst) m_cnt[k] = 16'h0;
         else if (c && m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("d%0d douta", k), 64'(douta_o[k]), 64'(m_out[k][0]));
         check($sformatf("d%0d douta_vld", k), 64'(douta_vld_o[k]), 64'(m_ov[k][0]));
         check($sformatf("d%0d doutb", k), 64'(doutb_o[k]), 64'(m_out[k][1]));
         check($sformatf("d%0d doutb_vld", k), 64'(doutb_vld_o[k]), 64'(m_ov[k][1]));
         check($sformatf("d%0d coll", k), 64'(coll_o[k]), 64'(m_coll[k]));
         check($sformatf("d%0d coll_cnt", k), 64'(coll_cnt_o[k]), 64'(m_cnt[k]));
      end
   endtask

   task automatic idle();
      rst = 1'b0;
      ena = 1'b0; wea = 4'h0; addra = '0; dina = '0; regcea = 1'b1;
      enb = 1'b0; web = 4'h0; addrb = '0; dinb = '0; regceb = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_coll[k] = 1'b0;
         m_cnt[k]  = 16'h0;
         for (int p = 0; p < 2; p++) begin
            m_s1[k][p] = '0; m_v1[k][p] = 1'b0;
            m_out[k][p] = '0; m_ov[k][p] = 1'b0;
         end
      end
      idle();
      rst = 1'b1;
      // Zero the array under reset; writes proceed while outputs stay cleared.
      for (int i = 0; i < 512; i++) begin
         ena = 1'b1; wea = 4'hF; addra = 10'(2*i);
         enb = 1'b1; web = 4'hF; addrb = 10'(2*i+1);
         cyc();
      end
      check("rst douta", 64'(douta_o[0]), 64'h0);
      check("rst coll_cnt", 64'(coll_cnt_o[0]), 64'h0);

      // Write then read with two-cycle latency.
      idle();
      ena = 1'b1; wea = 4'hF; addra = 10'd5; dina = 36'h123456789;
      cyc();
      wea = 4'h0;
      cyc();
      check("p1 d1 douta lat1", 64'(douta_o[1]), 64'h123456789);
      idle();
      cyc();
      check("p1 douta", 64'(douta_o[0]), 64'h123456789);
      check("p1 douta_vld", 64'(douta_vld_o[0]), 64'h1);

      // Write-first vs read-first on a partial write.
      ena = 1'b1; wea = 4'b0011; addra = 10'd7; dina = '1;
      cyc();
      check("p2 read-first", 64'(douta_o[1]), 64'h0);
      idle();
      cyc();
      check("p2 write-first", 64'(douta_o[0]), 64'h00003FFFF);

      // No-change port holds data and suppresses valid on a write.
      enb = 1'b1; web = 4'hF; addrb = 10'd3; dinb = 36'hAAA;
      cyc();
      web = 4'h0;
      cyc();
      check("p3 nc read", 64'(doutb_o[1]), 64'hAAA);
      check("p3 nc read vld", 64'(doutb_vld_o[1]), 64'h1);
      web = 4'hF; dinb = 36'h555;
      cyc();
      check("p3 nc hold", 64'(doutb_o[1]), 64'hAAA);
      check("p3 nc vld", 64'(doutb_vld_o[1]), 64'h0);

      // Write-write collision.
      idle();
      ena = 1'b1; wea = 4'hF; addra = 10'd9; dina = 36'h111111111;
      enb = 1'b1; web = 4'h3; addrb = 10'd9; dinb = 36'h222222222;
      cyc();
      check("p4 coll", 64'(coll_o[0]), 64'h1);
      check("p4 coll_cnt", 64'(coll_cnt_o[0]), 64'h1);
      idle();
      ena = 1'b1; addra = 10'd9;
      cyc();
      idle();
      cyc();
      check("p4 prio A", 64'(douta_o[0]), 64'h111111111);
      check("p4 coll clr", 64'(coll_o[0]), 64'h0);

      // Reset drops an in-flight read.
      ena = 1'b1; addra = 10'd5;
      cyc();
      idle();
      rst = 1'b1;
      cyc();
      check("p5 douta", 64'(douta_o[0]), 64'h0);
      check("p5 vld", 64'(douta_vld_o[0]), 64'h0);
      idle();
      cyc();
      check("p5 late vld", 64'(douta_vld_o[0]), 64'h0);
      ena = 1'b1; addra = 10'd5;
      cyc();
      idle();
      cyc();
      check("p5 mem kept", 64'(douta_o[0]), 64'h123456789);

      // Random traffic on a small address window to provoke collisions.
      for (int n = 0; n < 2000; n++) begin
         rst    = ($urandom_range(0, 49) == 0);
         ena    = $urandom_range(0, 1);
         enb    = $urandom_range(0, 1);
         wea    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
         web    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
         addra  = 10'($urandom_range(0, 15));
         addrb  = 10'($urandom_range(0, 15));
         dina   = {4'($urandom), 32'($urandom)};
         dinb   = {4'($urandom), 32'($urandom)};
         regcea = ($urandom_range(0, 3) != 0);
         regceb = ($urandom_range(0, 3) != 0);
         cyc();
      end

      // Counter saturation, then reset.
      idle();
      ena = 1'b1; wea = 4'h1; addra = 10'd0;
      enb = 1'b1; web = 4'h0; addrb = 10'd0;
      for (int n = 0; n < 65540; n++) cyc();
      check("p6 sat d0", 64'(coll_cnt_o[0]), 64'hFFFF);
      check("p6 sat d1", 64'(coll_cnt_o[1]), 64'hFFFF);
      rst = 1'b1;
      cyc();
      check("p6 rst cnt", 64'(coll_cnt_o[0]), 64'h0);
      check("p6 rst coll", 64'(coll_o[0]), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
